// File: rtl/safe_pkg.sv
// Shared types and constants for the safe keypad front end.
// Contents: FSM state enum, key codes, error pattern, timer width helper.
package safe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D1,
        ST_D2,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_e;

    localparam logic [3:0] KEY_ENTER   = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    localparam logic [7:0] ERR_PATTERN = 8'hEE;

    // Bits needed to hold (max duration - 1), since timers load N-1.
    function automatic int tmr_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter that saturates at zero.
// Ports: clk_i, rst_ni, load_i, load_val_i[W-1:0], done_o (count is zero).
module safe_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/safe_code_entry.sv
// Two-digit BCD code entry, unlock window and failure lockout for the safe.
// Ports: clk_1ms, reset (async active-low), key_valid, key_code[3:0],
//        data[7:0] and blank to the LCD stage, unlocked, alarm.
// Option: SAFE_CODE_PROGRAM_EN adds a code register reprogrammable in OPEN.
module safe_code_entry
    import safe_pkg::*;
#(
    parameter logic [7:0]  CODE       = 8'h42,
    parameter int unsigned OPEN_MS    = 3000,
    parameter int unsigned IDLE_MS    = 10000,
    parameter int unsigned MAX_FAILS  = 3,
    parameter int unsigned LOCKOUT_MS = 30000
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] data,
    output logic       blank,
    output logic       unlocked,
    output logic       alarm
);

    localparam int TW = tmr_w(OPEN_MS, IDLE_MS, LOCKOUT_MS);

    // Durations load as N-1 so the state holds for exactly N cycles.
    localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_MS - 1);
    localparam logic [TW-1:0] IDLE_LD = TW'(IDLE_MS - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_MS - 1);
    localparam logic [2:0]    MAXF    = 3'(MAX_FAILS);

    state_e        state_q;
    logic [7:0]    data_q;
    logic          blank_q;
    logic          unl_q;
    logic          alm_q;
    logic [2:0]    fail_q;
    logic [7:0]    code_w;
    logic          tmr_ld;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic is_dig;
    logic is_ent;
    logic is_clr;

    assign is_dig = key_valid && (key_code <= 4'd9);
    assign is_ent = key_valid && (key_code == KEY_ENTER);
    assign is_clr = key_valid && (key_code == KEY_CLEAR);

`ifdef SAFE_CODE_PROGRAM_EN
    logic [7:0] code_q;
    logic [1:0] pcnt_q;
    assign code_w = code_q;
`else
    assign code_w = CODE;
`endif

    always_comb begin
        tmr_ld  = 1'b0;
        tmr_val = IDLE_LD;
        unique case (state_q)
            ST_IDLE: tmr_ld = is_dig;
            ST_D1:   tmr_ld = is_dig | is_clr | tmr_done;
            ST_D2: begin
                tmr_ld = is_dig | is_clr | is_ent | tmr_done;
                if (is_ent && (data_q == code_w)) tmr_val = OPEN_LD;
            end
            ST_OPEN: begin
                tmr_ld = tmr_done | is_clr;
`ifdef SAFE_CODE_PROGRAM_EN
                if (!tmr_done && !is_clr &&
                    (is_dig || (is_ent && pcnt_q != 2'd2))) begin
                    tmr_ld  = 1'b1;
                    tmr_val = OPEN_LD;
                end else if (is_ent && pcnt_q == 2'd2) begin
                    tmr_ld = 1'b1;
                end
`endif
            end
            ST_FAIL: begin
                tmr_ld = 1'b1;
                if (fail_q == MAXF) tmr_val = LOCK_LD;
            end
            ST_LOCKOUT: tmr_ld = tmr_done;
            default:    tmr_ld = 1'b1;
        endcase
    end

    safe_timer #(.W(TW)) u_timer (
        .clk_i      (clk_1ms),
        .rst_ni     (reset),
        .load_i     (tmr_ld),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            blank_q <= 1'b1;
            unl_q   <= 1'b0;
            alm_q   <= 1'b0;
            fail_q  <= 3'd0;
`ifdef SAFE_CODE_PROGRAM_EN
            code_q  <= CODE;
            pcnt_q  <= 2'd0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_dig) begin
                        state_q <= ST_D1;
                        data_q  <= {key_code, 4'h0};
                        blank_q <= 1'b0;
                    end
                end
                ST_D1: begin
                    if (is_dig) begin
                        state_q     <= ST_D2;
                        data_q[3:0] <= key_code;
                    end else if (is_clr || tmr_done) begin
                        state_q <= ST_IDLE;
                        data_q  <= 8'h00;
                        blank_q <= 1'b1;
                    end
                end
                ST_D2: begin
                    if (is_ent) begin
                        if (data_q == code_w) begin
                            state_q <= ST_OPEN;
                            unl_q   <= 1'b1;
                            fail_q  <= 3'd0;
`ifdef SAFE_CODE_PROGRAM_EN
                            pcnt_q  <= 2'd0;
`endif
                        end else begin
                            state_q <= ST_FAIL;
                            fail_q  <= fail_q + 3'd1;
                        end
                    end else if (is_dig) begin
                        data_q <= {data_q[3:0], key_code};
                    end else if (is_clr || tmr_done) begin
                        state_q <= ST_IDLE;
                        data_q  <= 8'h00;
                        blank_q <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (tmr_done || is_clr) begin
                        state_q <= ST_IDLE;
                        unl_q   <= 1'b0;
                        data_q  <= 8'h00;
                        blank_q <= 1'b1;
                    end
`ifdef SAFE_CODE_PROGRAM_EN
                    else if (is_dig) begin
                        blank_q <= 1'b0;
                        if (pcnt_q == 2'd0) begin
                            data_q <= {key_code, 4'h0};
                            pcnt_q <= 2'd1;
                        end else begin
                            data_q <= (pcnt_q == 2'd1) ?
                                      {data_q[7:4], key_code} :
                                      {data_q[3:0], key_code};
                            pcnt_q <= 2'd2;
                        end
                    end else if (is_ent && pcnt_q == 2'd2) begin
                        code_q  <= data_q;
                        state_q <= ST_IDLE;
                        unl_q   <= 1'b0;
                        data_q  <= 8'h00;
                        blank_q <= 1'b1;
                    end
`endif
                end
                ST_FAIL: begin
                    if (fail_q == MAXF) begin
                        state_q <= ST_LOCKOUT;
                        alm_q   <= 1'b1;
                        data_q  <= ERR_PATTERN;
                        blank_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        data_q  <= 8'h00;
                        blank_q <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_done) begin
                        state_q <= ST_IDLE;
                        alm_q   <= 1'b0;
                        fail_q  <= 3'd0;
                        data_q  <= 8'h00;
                        blank_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    data_q  <= 8'h00;
                    blank_q <= 1'b1;
                    unl_q   <= 1'b0;
                    alm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data     = data_q;
    assign blank    = blank_q;
    assign unlocked = unl_q;
    assign alarm    = alm_q;

endmodule

// File: tb/tb_safe_code_entry.sv
// Directed bench for safe_code_entry with an expectation queue.
// Steps drive keys on the falling edge and check on the next falling edge.
module tb_safe_code_entry;

    logic       clk_1ms = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] data;
    logic       blank;
    logic       unlocked;
    logic       alarm;

    always #5 clk_1ms = ~clk_1ms;

    safe_code_entry dut (
        .clk_1ms   (clk_1ms),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .data      (data),
        .blank     (blank),
        .unlocked  (unlocked),
        .alarm     (alarm)
    );

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic       b;
        logic       u;
        logic       a;
    } exp_t;

    exp_t sb[$];
    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic push(input string t, input logic [7:0] d,
                        input logic b, input logic u, input logic a);
        exp_t e;
        e.tag = t;
        e.d = d;
        e.b = b;
        e.u = u;
        e.a = a;
        sb.push_back(e);
    endtask

    task automatic pop();
        exp_t e;
        e = sb.pop_front();
        ntot++;
        assert (data === e.d) npass++;
        else begin
            nfail++;
            $error("FAIL %s data got %h want %h", e.tag, data, e.d);
        end
        ntot++;
        assert (blank === e.b) npass++;
        else begin
            nfail++;
            $error("FAIL %s blank got %b want %b", e.tag, blank, e.b);
        end
        ntot++;
        assert (unlocked === e.u) npass++;
        else begin
            nfail++;
            $error("FAIL %s unlocked got %b want %b", e.tag, unlocked, e.u);
        end
        ntot++;
        assert (alarm === e.a) npass++;
        else begin
            nfail++;
            $error("FAIL %s alarm got %b want %b", e.tag, alarm, e.a);
        end
    endtask

    task automatic press(input string t, input logic [3:0] k,
                         input logic [7:0] d, input logic b,
                         input logic u, input logic a);
        push(t, d, b, u, a);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk_1ms);
        key_valid = 1'b0;
        pop();
    endtask

    task automatic step(input string t, input int n,
                        input logic [7:0] d, input logic b,
                        input logic u, input logic a);
        push(t, d, b, u, a);
        repeat (n) @(negedge clk_1ms);
        pop();
    endtask

    initial begin
        repeat (2) @(negedge clk_1ms);
        push("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        pop();
        reset = 1'b1;
        @(negedge clk_1ms);

        // correct code, exact open window
        press("k4",  4'h4, 8'h40, 1'b0, 1'b0, 1'b0);
        press("k2",  4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("ent", 4'hA, 8'h42, 1'b0, 1'b1, 1'b0);
        step("open_last", 2999, 8'h42, 1'b0, 1'b1, 1'b0);
        step("open_end",  1,    8'h00, 1'b1, 1'b0, 1'b0);

        // three failures into lockout
        for (int i = 0; i < 3; i++) begin
            press("f_k1",  4'h1, 8'h10, 1'b0, 1'b0, 1'b0);
            press("f_k2",  4'h2, 8'h12, 1'b0, 1'b0, 1'b0);
            press("f_ent", 4'hA, 8'h12, 1'b0, 1'b0, 1'b0);
            if (i < 2) step("f_idle", 1, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        step("lock_in", 1, 8'hEE, 1'b0, 1'b0, 1'b1);
        press("lock_k4",  4'h4, 8'hEE, 1'b0, 1'b0, 1'b1);
        press("lock_ent", 4'hA, 8'hEE, 1'b0, 1'b0, 1'b1);
        press("lock_clr", 4'hB, 8'hEE, 1'b0, 1'b0, 1'b1);
        step("lock_last", 29996, 8'hEE, 1'b0, 1'b0, 1'b1);
        step("lock_end",  1,     8'h00, 1'b1, 1'b0, 1'b0);

        // clear, then unlock and relock with CLEAR
        press("c_k7",  4'h7, 8'h70, 1'b0, 1'b0, 1'b0);
        press("c_clr", 4'hB, 8'h00, 1'b1, 1'b0, 1'b0);
        press("c_k4",  4'h4, 8'h40, 1'b0, 1'b0, 1'b0);
        press("c_k2",  4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("c_ent", 4'hA, 8'h42, 1'b0, 1'b1, 1'b0);
        press("relock", 4'hB, 8'h00, 1'b1, 1'b0, 1'b0);

        // idle timeout; ignored key does not restart it
        press("t_k5", 4'h5, 8'h50, 1'b0, 1'b0, 1'b0);
        press("t_kF", 4'hF, 8'h50, 1'b0, 1'b0, 1'b0);
        step("t_last", 9998, 8'h50, 1'b0, 1'b0, 1'b0);
        step("t_out",  1,    8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            press("g_k1",  4'h1, 8'h10, 1'b0, 1'b0, 1'b0);
            press("g_k2",  4'h2, 8'h12, 1'b0, 1'b0, 1'b0);
            press("g_ent", 4'hA, 8'h12, 1'b0, 1'b0, 1'b0);
            if (i < 2) step("g_noalarm", 1, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        step("g_lock",  1,     8'hEE, 1'b0, 1'b0, 1'b1);
        step("g_last",  29999, 8'hEE, 1'b0, 1'b0, 1'b1);
        step("g_end",   1,     8'h00, 1'b1, 1'b0, 1'b0);

        // shift-left entry, ENTER ignored in D1
        press("s_k9",  4'h9, 8'h90, 1'b0, 1'b0, 1'b0);
        press("s_k4",  4'h4, 8'h94, 1'b0, 1'b0, 1'b0);
        press("s_k2",  4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("s_ent", 4'hA, 8'h42, 1'b0, 1'b1, 1'b0);
`ifndef SAFE_CODE_PROGRAM_EN
        press("o_k1",  4'h1, 8'h42, 1'b0, 1'b1, 1'b0);
`endif
        press("s_clr", 4'hB, 8'h00, 1'b1, 1'b0, 1'b0);
        press("d1_k4", 4'h4, 8'h40, 1'b0, 1'b0, 1'b0);
        press("d1_ent", 4'hA, 8'h40, 1'b0, 1'b0, 1'b0);
        press("d1_k2", 4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("d1_clr", 4'hB, 8'h00, 1'b1, 1'b0, 1'b0);

        // async reset while open
        press("r_k4",  4'h4, 8'h40, 1'b0, 1'b0, 1'b0);
        press("r_k2",  4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("r_ent", 4'hA, 8'h42, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        push("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);
        pop();
        #1 reset = 1'b1;
        @(negedge clk_1ms);

`ifdef SAFE_CODE_PROGRAM_EN
        press("p_k4",  4'h4, 8'h40, 1'b0, 1'b0, 1'b0);
        press("p_k2",  4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("p_ent", 4'hA, 8'h42, 1'b0, 1'b1, 1'b0);
        press("p_n1",  4'h1, 8'h10, 1'b0, 1'b1, 1'b0);
        press("p_n7",  4'h7, 8'h17, 1'b0, 1'b1, 1'b0);
        press("p_st",  4'hA, 8'h00, 1'b1, 1'b0, 1'b0);
        press("q_k4",  4'h4, 8'h40, 1'b0, 1'b0, 1'b0);
        press("q_k2",  4'h2, 8'h42, 1'b0, 1'b0, 1'b0);
        press("q_ent", 4'hA, 8'h42, 1'b0, 1'b0, 1'b0);
        step("q_idle", 1, 8'h00, 1'b1, 1'b0, 1'b0);
        press("n_k1",  4'h1, 8'h10, 1'b0, 1'b0, 1'b0);
        press("n_k7",  4'h7, 8'h17, 1'b0, 1'b0, 1'b0);
        press("n_ent", 4'hA, 8'h17, 1'b0, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
